// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 4-bit character-LCD controller:
// FSM state encoding, instruction/nibble constants, 50 MHz default timings
// and the execution-time classifier for a written byte.
package lcd_pkg;

  // Controller states
  localparam logic [3:0] S_PWR_WAIT  = 4'd0;
  localparam logic [3:0] S_INIT_NIB  = 4'd1;
  localparam logic [3:0] S_INIT_WAIT = 4'd2;
  localparam logic [3:0] S_CFG       = 4'd3;
  localparam logic [3:0] S_BYTE_HI   = 4'd4;
  localparam logic [3:0] S_GAP       = 4'd5;
  localparam logic [3:0] S_BYTE_LO   = 4'd6;
  localparam logic [3:0] S_EXEC_WAIT = 4'd7;
  localparam logic [3:0] S_IDLE      = 4'd8;

  // Instructions and init nibbles
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [3:0] NIB_INIT  = 4'h3;
  localparam logic [3:0] NIB_4BIT  = 4'h2;

  // Default timings in 50 MHz clock cycles
  localparam int unsigned DEF_T_POWERON = 750000;
  localparam int unsigned DEF_T_INIT_A  = 205000;
  localparam int unsigned DEF_T_INIT_B  = 5000;
  localparam int unsigned DEF_T_CMD     = 2000;
  localparam int unsigned DEF_T_CLEAR   = 82000;
  localparam int unsigned DEF_E_PULSE   = 12;
  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_GAP     = 50;
  localparam int unsigned DEF_CW        = 20;

  // Default configuration bytes
  localparam logic [7:0] DEF_CFG_FUNCTION = 8'h28;
  localparam logic [7:0] DEF_CFG_ENTRY    = 8'h06;
  localparam logic [7:0] DEF_CFG_DISPLAY  = 8'h0C;

  // Clear (0x01) and Return Home (0x02/0x03) need the long execution wait;
  // 0x00 shares the same top bits and is grouped with them.
  function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
    return !rs && ((b == CMD_CLEAR) ||
                   (b[7:1] == CMD_HOME[7:1]) ||
                   (b[7:1] == 7'h00));
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Single-nibble write strobe for the LCD bus.
// A start pulse latches nibble/rs; the bus then shows RS/data for T_SETUP
// cycles with E low, E high for E_PULSE cycles, then E low with data held
// for one cycle, during which done pulses.
// Ports: clk, rst_n (async active-low), start, nibble[3:0], rs ->
//        done (1-cycle pulse), lcd_e, lcd_data[3:0], lcd_rs (all registered).
module lcd_nibble_strobe #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned E_PULSE = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       done,
  output logic       lcd_e,
  output logic [3:0] lcd_data,
  output logic       lcd_rs
);

  localparam int unsigned LAST = T_SETUP + E_PULSE;
  localparam int unsigned PW   = $clog2(LAST + 1);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_inc_c;
  logic          busy;

  assign phase_inc_c = phase + PW'(1);

  // phase counts cycles since the start edge; E is high for phases
  // T_SETUP..LAST-1 and done marks the hold cycle at phase LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      phase    <= '0;
      done     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 4'h0;
      lcd_rs   <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      phase    <= '0;
      done     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= nibble;
      lcd_rs   <= rs;
    end else if (busy) begin
      if (phase == PW'(LAST)) begin
        busy  <= 1'b0;
        phase <= '0;
        done  <= 1'b0;
        lcd_e <= 1'b0;
      end else begin
        phase <= phase_inc_c;
        lcd_e <= (phase_inc_c >= PW'(T_SETUP)) && (phase_inc_c < PW'(LAST));
        done  <= (phase_inc_c == PW'(LAST));
      end
    end
  end

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780-compatible 4-bit character-LCD controller (Spartan-3E starter board).
// Runs the power-on init nibbles, writes the configuration bytes, then accepts
// command/data bytes from a host over a valid/ready handshake, splitting each
// byte into two nibble strobes followed by the instruction's execution wait.
// Ports: Clock, Reset (async active-low), iData[7:0], iRS, iValid ->
//        oReady, oInitDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite
//        (tied 0), oLCD_StrataFlashControl (tied 1), oLCD_Data[3:0] (DB7..DB4).
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERON    = DEF_T_POWERON,
  parameter int unsigned T_INIT_A     = DEF_T_INIT_A,
  parameter int unsigned T_INIT_B     = DEF_T_INIT_B,
  parameter int unsigned T_CMD        = DEF_T_CMD,
  parameter int unsigned T_CLEAR      = DEF_T_CLEAR,
  parameter int unsigned E_PULSE      = DEF_E_PULSE,
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_GAP        = DEF_T_GAP,
  parameter logic [7:0]  CFG_FUNCTION = DEF_CFG_FUNCTION,
  parameter logic [7:0]  CFG_ENTRY    = DEF_CFG_ENTRY,
  parameter logic [7:0]  CFG_DISPLAY  = DEF_CFG_DISPLAY,
  parameter int unsigned CW           = DEF_CW
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  logic [3:0]    state, state_next_c;
  logic [CW-1:0] cnt;
  logic [1:0]    step, step_next_c;
  logic [1:0]    cfg, cfg_next_c;
  logic [7:0]    byte_q, byte_next_c;
  logic          rs_q, rs_next_c;

  logic [CW-1:0] wait_c;
  logic          expired_c;
  logic [7:0]    cfg_byte_c;
  logic          strobe_start_c;
  logic [3:0]    strobe_nib_c;
  logic          strobe_rs_c;
  logic          strobe_done;

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // Length of the wait owned by the current state
  always_comb begin
    wait_c = CW'(T_CMD);
    case (state)
      S_PWR_WAIT: wait_c = CW'(T_POWERON);
      S_INIT_WAIT: begin
        case (step)
          2'd0:    wait_c = CW'(T_INIT_A);
          2'd1:    wait_c = CW'(T_INIT_B);
          default: wait_c = CW'(T_CMD);
        endcase
      end
      S_GAP:       wait_c = CW'(T_GAP);
      S_EXEC_WAIT: wait_c = is_long_cmd(byte_q, rs_q) ? CW'(T_CLEAR) : CW'(T_CMD);
      default:     wait_c = CW'(T_CMD);
    endcase
  end

  // Counter restarts at 0 on state entry, so N cycles end at N-1
  assign expired_c = (cnt == (wait_c - CW'(1)));

  // Configuration byte for the current cfg index
  always_comb begin
    case (cfg)
      2'd0:    cfg_byte_c = CFG_FUNCTION;
      2'd1:    cfg_byte_c = CFG_ENTRY;
      2'd2:    cfg_byte_c = CFG_DISPLAY;
      default: cfg_byte_c = CMD_CLEAR;
    endcase
  end

  // Next-state logic; nibble strobes are launched on entry to a strobe state
  always_comb begin
    state_next_c   = state;
    step_next_c    = step;
    cfg_next_c     = cfg;
    byte_next_c    = byte_q;
    rs_next_c      = rs_q;
    strobe_start_c = 1'b0;
    strobe_nib_c   = 4'h0;
    strobe_rs_c    = 1'b0;
    case (state)
      S_PWR_WAIT: begin
        if (expired_c) begin
          state_next_c   = S_INIT_NIB;
          step_next_c    = 2'd0;
          strobe_start_c = 1'b1;
          strobe_nib_c   = NIB_INIT;
        end
      end
      S_INIT_NIB: begin
        if (strobe_done) state_next_c = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (expired_c) begin
          if (step == 2'd3) begin
            state_next_c = S_CFG;
            cfg_next_c   = 2'd0;
          end else begin
            state_next_c   = S_INIT_NIB;
            step_next_c    = step + 2'd1;
            strobe_start_c = 1'b1;
            strobe_nib_c   = (step == 2'd2) ? NIB_4BIT : NIB_INIT;
          end
        end
      end
      S_CFG: begin
        state_next_c   = S_BYTE_HI;
        byte_next_c    = cfg_byte_c;
        rs_next_c      = 1'b0;
        strobe_start_c = 1'b1;
        strobe_nib_c   = cfg_byte_c[7:4];
      end
      S_BYTE_HI: begin
        if (strobe_done) state_next_c = S_GAP;
      end
      S_GAP: begin
        if (expired_c) begin
          state_next_c   = S_BYTE_LO;
          strobe_start_c = 1'b1;
          strobe_nib_c   = byte_q[3:0];
          strobe_rs_c    = rs_q;
        end
      end
      S_BYTE_LO: begin
        if (strobe_done) state_next_c = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        if (expired_c) begin
          if (!oInitDone && (cfg != 2'd3)) begin
            state_next_c = S_CFG;
            cfg_next_c   = cfg + 2'd1;
          end else begin
            state_next_c = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (iValid && oReady) begin
          state_next_c   = S_BYTE_HI;
          byte_next_c    = iData;
          rs_next_c      = iRS;
          strobe_start_c = 1'b1;
          strobe_nib_c   = iData[7:4];
          strobe_rs_c    = iRS;
        end
      end
      default: state_next_c = S_PWR_WAIT;
    endcase
  end

  // State, wait counter and handshake registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_PWR_WAIT;
      cnt       <= '0;
      step      <= 2'd0;
      cfg       <= 2'd0;
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
      oReady    <= 1'b0;
      oInitDone <= 1'b0;
    end else begin
      state     <= state_next_c;
      cnt       <= (state_next_c != state) ? '0 : (cnt + CW'(1));
      step      <= step_next_c;
      cfg       <= cfg_next_c;
      byte_q    <= byte_next_c;
      rs_q      <= rs_next_c;
      oReady    <= (state_next_c == S_IDLE);
      oInitDone <= oInitDone | (state_next_c == S_IDLE);
    end
  end

  lcd_nibble_strobe #(
    .T_SETUP (T_SETUP),
    .E_PULSE (E_PULSE)
  ) u_strobe (
    .clk      (Clock),
    .rst_n    (Reset),
    .start    (strobe_start_c),
    .nibble   (strobe_nib_c),
    .rs       (strobe_rs_c),
    .done     (strobe_done),
    .lcd_e    (oLCD_Enabled),
    .lcd_data (oLCD_Data),
    .lcd_rs   (oLCD_RegisterSelect)
  );

endmodule
